dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128, number of 64-bit words stored (byte capacity DEPTH_WORDS*8).
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  the CPU memory stage presents a request.
REQ-006 SHALL have port req_ready  output  1  the block can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data, little-endian, low bytes used for sizes below 8.
REQ-010 SHALL have port req_size  input  4  transfer size in bytes.
REQ-011 SHALL have port resp_valid  output  1  a response is presented.
REQ-012 SHALL have port resp_ready  input  1  the requester accepts the response.
REQ-013 SHALL have port resp_rdata  output  64  load data, zero-extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  the request was illegal and had no effect.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-016 Acceptance: on an edge with req_valid & req_ready, the block SHALL capture write, addr, wdata and size, load the counter with LATENCY-1, and go to WAIT.
REQ-017 WAIT SHALL decrement the counter each edge; at the edge where the counter is 0, the block SHALL perform the access, register resp_rdata/resp_err, and go to RESP.
REQ-018 Net latency: a request accepted at edge N SHALL have resp_valid high immediately after edge N+LATENCY.
REQ-019 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until an edge with resp_ready=1, then go to IDLE; the next acceptance can occur one edge later at the earliest.
REQ-020 Legal sizes SHALL be 1, 2, 4 and 8; a request is legal only if size is legal, addr mod size == 0, and addr < DEPTH_WORDS*8 (full 64-bit compare).
REQ-021 For an illegal request, resp_err SHALL be 1, resp_rdata SHALL be 0, and memory SHALL be unchanged.
REQ-022 A legal store SHALL update only bytes addr..addr+size-1, using byte enables within word addr[63:3], and SHALL commit at the REQ-017 edge.
REQ-023 A legal load SHALL return bytes addr..addr+size-1 in resp_rdata[8*size-1:0] with the upper bits zero.
REQ-024 A load issued after the response handshake of a store SHALL observe the stored data.
REQ-025 req_valid while not in IDLE SHALL be ignored; request inputs SHALL be sampled only at acceptance.

Reset
REQ-026 While reset is asserted, the FSM SHALL be IDLE, req_ready SHALL be 0, resp_valid 0, resp_rdata 0, resp_err 0, and the counter 0.
REQ-027 req_ready SHALL be a registered output that rises at the first edge after reset deasserts.
REQ-028 Reset during WAIT SHALL abort the request: no store commits and no response is produced.
REQ-029 Reset during RESP SHALL drop the response.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the legal-size constants (1, 2, 4, 8) and the default DEPTH_WORDS/LATENCY.
REQ-032 The storage array SHALL be a sub-module dmem_bytearray: one write port with 8 byte enables and one read port of one 64-bit word.
REQ-033 The FSM, counter, legality check and byte lane alignment SHALL reside in dmem_responder.

Verification
REQ-034 Store 8B 0x1122334455667788 @0x10, then load 8B @0x10 -> resp_rdata=0x1122334455667788, err=0, resp_valid exactly LATENCY edges after each acceptance.
REQ-035 After REQ-034, store 1B 0xAB @0x13, then load 8B @0x10 -> 0x11223344AB667788; load 2B @0x12 -> 0x000000000000AB66.
REQ-036 Load 4B @0x12 (misaligned), size=3, and addr=0x400 with DEPTH 128 -> err=1, rdata=0; a following load 8B @0x10 is unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable and req_ready=0 throughout; handshake -> req_ready=1 next cycle.
REQ-038 Assert reset one cycle after accepting store 8B 0xFF.. @0x20 -> no response; after reset, load @0x20 returns the pre-store value and req_ready rises one edge after deassertion.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types, constants and helpers for the data memory responder
//
// Holds the FSM state enum, the legal transfer sizes, default geometry/latency
// and a helper that maps a transfer size onto its byte-lane mask.

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] SIZE_B = 4'd1;
  localparam logic [3:0] SIZE_H = 4'd2;
  localparam logic [3:0] SIZE_W = 4'd4;
  localparam logic [3:0] SIZE_D = 4'd8;

  localparam int DEFAULT_DEPTH_WORDS = 128;
  localparam int DEFAULT_LATENCY     = 3;
  localparam int CNT_W               = 4;

  // Lane mask of a transfer at byte offset 0; all-zero marks an illegal size.
  function automatic logic [7:0] size_lane_mask(input logic [3:0] size);
    logic [7:0] mask;
    case (size)
      SIZE_B:  mask = 8'h01;
      SIZE_H:  mask = 8'h03;
      SIZE_W:  mask = 8'h0F;
      SIZE_D:  mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_bytearray.sv
// rtl/dmem_bytearray.sv - 64-bit word storage with byte-enabled write and asynchronous word read
//
// Ports:
//   clk      input   clock; writes commit on the rising edge
//   wr_en    input   write strobe
//   wr_addr  input   word index for the write
//   wr_be    input   8 byte enables, bit i guards wr_data[8*i+7:8*i]
//   wr_data  input   64-bit write data, already lane-aligned
//   rd_addr  input   word index for the read
//   rd_data  output  64-bit word at rd_addr (combinational)
// Contents are intentionally not reset.

module dmem_bytearray #(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_be,
  input  logic [63:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder for a CPU memory stage
//
// Ports:
//   clk         input   single clock
//   reset       input   asynchronous active-high reset
//   req_valid   input   request presented
//   req_ready   output  registered; high only in IDLE
//   req_write   input   1 = store, 0 = load
//   req_addr    input   64-bit byte address
//   req_wdata   input   store data, low bytes used for small sizes
//   req_size    input   transfer size in bytes (1, 2, 4, 8 legal)
//   resp_valid  output  response presented (RESP state)
//   resp_ready  input   requester accepts the response
//   resp_rdata  output  zero-extended load data; 0 for stores and errors
//   resp_err    output  request was illegal and had no effect

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int             AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0]    MEM_BYTES = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [3:0]       size_q, size_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [63:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  // Legality and lane alignment of the captured request.
  logic [7:0]    lane_mask;
  logic [2:0]    byte_off;
  logic [5:0]    lane_shift;
  logic          misaligned;
  logic          in_range;
  logic          legal;
  logic [7:0]    wr_be;
  logic [63:0]   wr_data;
  logic [63:0]   data_mask;
  logic [63:0]   mem_rdata;
  logic [63:0]   rd_aligned;
  logic [AW-1:0] word_idx;
  logic          do_access;
  logic          mem_we;

  assign lane_mask  = size_lane_mask(size_q);
  assign byte_off   = addr_q[2:0];
  assign lane_shift = {byte_off, 3'b000};
  // Legal sizes are powers of two, so size-1 is the alignment mask.
  assign misaligned = (addr_q[3:0] & (size_q - 4'd1)) != 4'd0;
  assign in_range   = addr_q < MEM_BYTES;
  assign legal      = (lane_mask != 8'h00) && !misaligned && in_range;
  assign word_idx   = addr_q[AW+2:3];
  assign wr_be      = lane_mask << byte_off;
  assign wr_data    = wdata_q << lane_shift;
  assign rd_aligned = (mem_rdata >> lane_shift) & data_mask;

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < 8; i++) begin
      data_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
  end

  // The access edge is the last WAIT edge; stores commit there.
  assign do_access = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_we    = do_access && write_q && legal;

  dmem_bytearray #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bytearray (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_addr(word_idx),
    .wr_be  (wr_be),
    .wr_data(wr_data),
    .rd_addr(word_idx),
    .rd_data(mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        // req_ready_q is low on the first IDLE cycle after reset.
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          resp_err_d   = !legal;
          resp_rdata_d = (legal && !write_q) ? rd_aligned : 64'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      size_q       <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-array model

module tb_dmem_responder;

  localparam int DEPTH   = 128;
  localparam int LAT     = 3;
  localparam int NBYTES  = DEPTH * 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [3:0]  req_size = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [NBYTES];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: memory as a flat byte array, rules applied directly.
  function automatic bit ref_legal(input logic [63:0] a, input logic [3:0] s);
    if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) return 1'b0;
    if ((a % 64'(s)) != 64'd0) return 1'b0;
    if (a >= 64'(NBYTES)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                              input logic [3:0] s, output logic [63:0] erd, output logic eerr);
    erd  = 64'd0;
    eerr = 1'b0;
    if (!ref_legal(a, s)) begin
      eerr = 1'b1;
    end else begin
      for (int i = 0; i < int'(s); i++) begin
        if (w) model_mem[int'(a) + i] = d[8*i +: 8];
        else   erd[8*i +: 8] = model_mem[int'(a) + i];
      end
    end
  endtask

  task automatic scramble_inputs();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size  = 4'($urandom_range(0, 15));
  endtask

  // Waits for req_ready, presents one request, then counts edges until resp_valid.
  // Junk is driven on the request inputs while the request is in flight.
  task automatic send_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [3:0] s, output int lat, output bit to);
    int guard;
    to    = 1'b0;
    lat   = 0;
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      to = 1'b1;
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
    @(posedge clk);
    #1;
    scramble_inputs();
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid !== 1'b1) scramble_inputs();
    end
    req_valid = 1'b0;
    if (resp_valid !== 1'b1) to = 1'b1;
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready_low: got %b want 0", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready_rise: got %b want 1", req_ready);
    end
  endtask

  // Memory is not reset, so every word is written once to give the model known contents.
  task automatic test_fill();
    logic [63:0] d, erd;
    logic        eerr;
    int          lat;
    bit          to;
    for (int i = 0; i < DEPTH; i++) begin
      d = {$urandom, $urandom};
      model_access(1'b1, 64'(i * 8), d, 4'd8, erd, eerr);
      send_req(1'b1, 64'(i * 8), d, 4'd8, lat, to);
      ack_resp();
      checks++;
      if (to || resp_err_seen_bad(eerr) || lat != LAT) begin
        errors++;
        $display("FAIL fill_store[%0d]: timeout=%0d lat=%0d want %0d", i, to, lat, LAT);
      end
    end
  endtask

  // Captures resp_err/resp_rdata right after a response is seen, for the fill loop.
  logic [63:0] last_rdata;
  logic        last_err;
  always @(posedge clk) begin
    if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
      last_rdata <= resp_rdata;
      last_err   <= resp_err;
    end
  end

  function automatic bit resp_err_seen_bad(input logic eerr);
    return (last_err !== eerr) || (last_rdata !== 64'd0);
  endfunction

  task automatic test_store_load();
    logic        w   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] a   [5] = '{64'h10, 64'h10, 64'h13, 64'h10, 64'h12};
    logic [63:0] d   [5] = '{64'h1122334455667788, 64'h0, 64'hDEADBEEFCAFE00AB, 64'h0, 64'h0};
    logic [3:0]  s   [5] = '{4'd8, 4'd8, 4'd1, 4'd8, 4'd2};
    logic [63:0] exp [5] = '{64'h0, 64'h1122334455667788, 64'h0, 64'h11223344AB667788, 64'h000000000000AB66};
    logic [63:0] erd;
    logic        eerr;
    int          lat;
    bit          to;
    for (int i = 0; i < 5; i++) begin
      model_access(w[i], a[i], d[i], s[i], erd, eerr);
      send_req(w[i], a[i], d[i], s[i], lat, to);
      checks++;
      if (to || resp_rdata !== exp[i] || resp_err !== 1'b0 || lat != LAT) begin
        errors++;
        $display("FAIL store_load[%0d]: got rdata=%h err=%b lat=%0d to=%0d want rdata=%h err=0 lat=%0d",
                 i, resp_rdata, resp_err, lat, to, exp[i], LAT);
      end
      ack_resp();
    end
  endtask

  task automatic test_illegal();
    logic        w   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] a   [7] = '{64'h12, 64'h10, 64'h400, 64'h400, 64'h11, 64'h8000000000000010, 64'h10};
    logic [3:0]  s   [7] = '{4'd4, 4'd3, 4'd8, 4'd8, 4'd2, 4'd8, 4'd8};
    logic        xe  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] exp [7] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h11223344AB667788};
    logic [63:0] erd;
    logic        eerr;
    int          lat;
    bit          to;
    for (int i = 0; i < 7; i++) begin
      model_access(w[i], a[i], 64'hFFFF_FFFF_FFFF_FFFF, s[i], erd, eerr);
      send_req(w[i], a[i], 64'hFFFF_FFFF_FFFF_FFFF, s[i], lat, to);
      checks++;
      if (to || resp_rdata !== exp[i] || resp_err !== xe[i] || lat != LAT) begin
        errors++;
        $display("FAIL illegal[%0d]: got rdata=%h err=%b lat=%0d to=%0d want rdata=%h err=%b lat=%0d",
                 i, resp_rdata, resp_err, lat, to, exp[i], xe[i], LAT);
      end
      ack_resp();
    end
  endtask

  task automatic test_boundary();
    logic [63:0] a [4] = '{64'h3F8, 64'h3FF, 64'h3FE, 64'h0};
    logic [3:0]  s [4] = '{4'd8, 4'd1, 4'd2, 4'd8};
    logic [63:0] erd;
    logic        eerr;
    int          lat;
    bit          to;
    for (int i = 0; i < 4; i++) begin
      model_access(1'b0, a[i], 64'd0, s[i], erd, eerr);
      send_req(1'b0, a[i], 64'd0, s[i], lat, to);
      checks++;
      if (to || resp_rdata !== erd || resp_err !== eerr || lat != LAT) begin
        errors++;
        $display("FAIL boundary[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, resp_rdata, resp_err, lat, erd, eerr, LAT);
      end
      ack_resp();
    end
  endtask

  task automatic test_stall();
    logic [63:0] erd;
    logic        eerr;
    int          lat;
    bit          to;
    model_access(1'b0, 64'h10, 64'd0, 4'd8, erd, eerr);
    send_req(1'b0, 64'h10, 64'd0, 4'd8, lat, to);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (to || resp_valid !== 1'b1 || resp_rdata !== erd || resp_err !== eerr || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                 c, resp_valid, resp_rdata, resp_err, req_ready, erd, eerr);
      end
    end
    ack_resp();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] erd;
    logic        eerr;
    int          lat;
    bit          to;
    int          guard;
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    req_size  = 4'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_assert: got valid=%b ready=%b want 0 0", resp_valid, req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_wait_no_resp[%0d]: got valid=%b want 0", c, resp_valid);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_ready_low: got %b want 0", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_ready_rise: got %b want 1", req_ready);
    end
    model_access(1'b0, 64'h20, 64'd0, 4'd8, erd, eerr);
    send_req(1'b0, 64'h20, 64'd0, 4'd8, lat, to);
    checks++;
    if (to || resp_rdata !== erd || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_no_commit: got rdata=%h err=%b want rdata=%h err=0",
               resp_rdata, resp_err, erd);
    end
    ack_resp();
  endtask

  task automatic test_reset_in_resp();
    int lat;
    bit to;
    send_req(1'b0, 64'h18, 64'd0, 4'd8, lat, to);
    reset = 1'b1;
    #1;
    checks++;
    if (to || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp_drop: got valid=%b rdata=%h err=%b want 0 0 0",
               resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic        w, eerr;
    logic [63:0] a, d, erd;
    logic [3:0]  s;
    int          r, r2, lat;
    bit          to;
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 19);
      s  = (r < 17) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
      r2 = $urandom_range(0, 9);
      a  = 64'($urandom_range(0, NBYTES - 1));
      if (r2 < 7)       a = a & ~(64'(s) - 64'd1);
      else if (r2 == 7) a = 64'(NBYTES) + 64'($urandom_range(0, 255));
      else if (r2 == 8) a = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      model_access(w, a, d, s, erd, eerr);
      send_req(w, a, d, s, lat, to);
      checks++;
      if (to || resp_rdata !== erd || resp_err !== eerr || lat != LAT) begin
        errors++;
        $display("FAIL random[%0d] w=%b a=%h s=%0d: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 n, w, a, s, resp_rdata, resp_err, lat, erd, eerr, LAT);
      end
      ack_resp();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_illegal();
    test_boundary();
    test_stall();
    test_reset_in_wait();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
